// File: rtl/m68_bus_responder_if.sv
// 68000-style asynchronous bus between a TG68 core (master) and a memory-mapped responder (slave).
// Strobes (as, uds, lds) and dtack are active-low, as on the real 68000 pins.
interface m68_bus_responder_if;
    logic [31:0] addr;
    logic [15:0] data_out;
    logic        as;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        intack;
    logic [15:0] data_in;
    logic        dtack;
    logic        sel;

    modport master (
        output addr, data_out, as, uds, lds, rw, intack,
        input  data_in, dtack, sel
    );

    modport slave (
        input  addr, data_out, as, uds, lds, rw, intack,
        output data_in, dtack, sel
    );
endinterface

// File: rtl/m68_bus_responder.sv
// 4 KB word-wide memory responder for a 68000 bus with programmable wait states.
// Define M68_RESP_INTACK_EN to also answer interrupt-acknowledge cycles with INT_VECTOR.
module m68_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h00FF_0000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  INT_VECTOR  = 8'h40
) (
    input  logic              clk,
    input  logic              rst_n,
    m68_bus_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        dtack_q, dtack_d;
    logic        sel_q, sel_d;
    logic [15:0] data_in_q, data_in_d;

    // Captured bus cycle; held for the whole cycle so later addr/data changes are ignored.
    logic [10:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic [15:0] wdata_q, wdata_d;
    logic        intack_q, intack_d;

    logic [15:0] mem [0:2047];
    logic [15:0] rd_word;
    logic        mem_we;
    logic        addr_hit;
    logic        int_hit;
    logic        hit;

    assign addr_hit = (bus.addr[31:12] == BASE_ADDR[31:12]);

`ifdef M68_RESP_INTACK_EN
    logic unused_addr0;
    assign int_hit      = bus.intack;
    assign unused_addr0 = bus.addr[0];
`else
    logic unused_bits;
    assign int_hit     = 1'b0;
    assign unused_bits = ^{bus.addr[0], bus.intack};
`endif

    assign hit     = !bus.as && (addr_hit || int_hit);
    assign rd_word = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        dtack_d   = dtack_q;
        sel_d     = sel_q;
        data_in_d = data_in_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        wdata_d   = wdata_q;
        intack_d  = intack_q;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d  = WAIT;
                    wcnt_d   = 4'(WAIT_STATES);
                    sel_d    = 1'b1;
                    addr_d   = bus.addr[11:1];
                    rw_d     = bus.rw;
                    uds_d    = bus.uds;
                    lds_d    = bus.lds;
                    wdata_d  = bus.data_out;
                    intack_d = int_hit;
                end
            end
            WAIT: begin
                if (bus.as) begin
                    // Master abandoned the cycle before acknowledge: nothing is written.
                    state_d = IDLE;
                    wcnt_d  = 4'd0;
                    sel_d   = 1'b0;
                end else if (wcnt_q == 4'd0) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                    mem_we  = !rw_q && !intack_q;
                    if (intack_q) begin
                        data_in_d = {8'h00, INT_VECTOR};
                    end else if (rw_q) begin
                        data_in_d = rd_word;
                    end else begin
                        data_in_d = 16'h0000;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.as) begin
                    state_d   = IDLE;
                    dtack_d   = 1'b1;
                    sel_d     = 1'b0;
                    data_in_d = 16'h0000;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= 4'd0;
            dtack_q   <= 1'b1;
            sel_q     <= 1'b0;
            data_in_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            dtack_q   <= dtack_d;
            sel_q     <= sel_d;
            data_in_q <= data_in_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        rw_q     <= rw_d;
        uds_q    <= uds_d;
        lds_q    <= lds_d;
        wdata_q  <= wdata_d;
        intack_q <= intack_d;
    end

    // mem_we is only raised from WAIT, which an asserted rst_n forces away from.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!uds_q) mem[addr_q][15:8] <= wdata_q[15:8];
            if (!lds_q) mem[addr_q][7:0]  <= wdata_q[7:0];
        end
    end

    assign bus.dtack   = dtack_q;
    assign bus.sel     = sel_q;
    assign bus.data_in = data_in_q;

endmodule

// File: tb/tb_m68_bus_responder.sv
// Directed bench for m68_bus_responder: scoreboarded reads against a small memory model,
// wait-state latency, lane masking, abort, reset behaviour and (optional) interrupt acknowledge.
module tb_m68_bus_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] exp_q [$];
    logic [15:0] model [int];

    m68_bus_responder_if bus();

    m68_bus_responder #(
        .BASE_ADDR  (32'h00FF_0000),
        .WAIT_STATES(2),
        .INT_VECTOR (8'h40)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for dtack to reach lvl, sampling 1 time unit after each rising edge.
    task automatic wait_dtack(input logic lvl, input int budget, output int n);
        n = 0;
        while (bus.dtack !== lvl && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_bus(input string tag);
        int n;
        @(negedge clk);
        bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1; bus.intack = 1'b0;
        wait_dtack(1'b1, 8, n);
        check({tag, "_rel_dtack"}, 32'(bus.dtack), 32'd1);
        check({tag, "_rel_sel"}, 32'(bus.sel), 32'd0);
        check({tag, "_rel_data"}, 32'(bus.data_in), 32'h0);
    endtask

    task automatic run_cycle(input string tag, input logic [31:0] a, input logic [15:0] wd,
                             input logic r, input logic u, input logic l, input logic ia,
                             input int budget, output logic acked, output int edges,
                             output logic [15:0] rd, output logic sel1, output logic sel_any);
        @(negedge clk);
        bus.addr = a; bus.data_out = wd; bus.rw = r;
        bus.uds = u; bus.lds = l; bus.intack = ia; bus.as = 1'b0;
        acked = 1'b0; edges = 0; rd = '0; sel1 = 1'b0; sel_any = 1'b0;
        while (!acked && edges < budget) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) sel1 = bus.sel;
            sel_any = sel_any | bus.sel;
            if (bus.dtack === 1'b0) begin
                acked = 1'b1;
                rd = bus.data_in;
            end
        end
        if (acked) begin
            release_bus(tag);
        end else begin
            @(negedge clk);
            bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1; bus.intack = 1'b0;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [15:0] d, input logic u, input logic l);
        int idx;
        logic [15:0] w;
        idx = int'(a[11:1]);
        w = model.exists(idx) ? model[idx] : 16'hxxxx;
        if (!u) w[15:8] = d[15:8];
        if (!l) w[7:0]  = d[7:0];
        model[idx] = w;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [15:0] d,
                            input logic u, input logic l);
        logic acked, s1, sa;
        int e;
        logic [15:0] rd;
        model_write(a, d, u, l);
        run_cycle(tag, a, d, 1'b0, u, l, 1'b0, 16, acked, e, rd, s1, sa);
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_lat"}, 32'(e), 32'd4);
        check({tag, "_sel"}, 32'(s1), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, output logic [15:0] rd);
        logic acked, s1, sa;
        int e;
        logic [15:0] exp;
        exp_q.push_back(model[int'(a[11:1])]);
        run_cycle(tag, a, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16, acked, e, rd, s1, sa);
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_lat"}, 32'(e), 32'd4);
        exp = exp_q.pop_front();
        check({tag, "_data"}, 32'(rd), 32'(exp));
    endtask

    initial begin
        logic acked, s1, sa;
        int e;
        logic [15:0] rd;
        logic saw_dtack;
        logic [15:0] exp;

        bus.addr = '0; bus.data_out = '0; bus.as = 1'b1; bus.uds = 1'b1;
        bus.lds = 1'b1; bus.rw = 1'b1; bus.intack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dtack", 32'(bus.dtack), 32'd1);
        check("reset_sel", 32'(bus.sel), 32'd0);
        check("reset_data", 32'(bus.data_in), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-word write then read back, with 2 wait states.
        do_write("w_beef", 32'h00FF_0010, 16'hBEEF, 1'b0, 1'b0);
        do_read("r_beef", 32'h00FF_0010, rd);
        check("beef_const", 32'(rd), 32'hBEEF);

        // Byte lanes.
        do_write("w_1234", 32'h00FF_0020, 16'h1234, 1'b0, 1'b0);
        do_write("w_upper", 32'h00FF_0020, 16'hAB00, 1'b0, 1'b1);
        do_read("r_ab34", 32'h00FF_0020, rd);
        check("ab34_const", 32'(rd), 32'hAB34);
        do_write("w_lower", 32'h00FF_0020, 16'h00CD, 1'b1, 1'b0);
        do_write("w_nolane", 32'h00FF_0020, 16'hFFFF, 1'b1, 1'b1);
        do_read("r_odd", 32'h00FF_0021, rd);
        check("abcd_const", 32'(rd), 32'hABCD);

        // Out-of-window cycle is never claimed.
        run_cycle("miss", 32'h0000_0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 20, acked, e, rd, s1, sa);
        check("miss_dtack", 32'(acked), 32'd0);
        check("miss_sel", 32'(sa), 32'd0);

        // Abort during wait states.
        do_write("w_7777", 32'h00FF_0030, 16'h7777, 1'b0, 1'b0);
        @(negedge clk);
        bus.addr = 32'h00FF_0030; bus.data_out = 16'h5555; bus.rw = 1'b0;
        bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        @(posedge clk); #1;
        check("abort_sel_capture", 32'(bus.sel), 32'd1);
        @(negedge clk);
        bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1;
        saw_dtack = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.dtack !== 1'b1) saw_dtack = 1'b1;
        end
        check("abort_no_dtack", 32'(saw_dtack), 32'd0);
        check("abort_sel_drop", 32'(bus.sel), 32'd0);
        do_read("r_7777", 32'h00FF_0030, rd);
        check("abort_word_const", 32'(rd), 32'h7777);

        // Address moves after capture; the captured address must be the one written.
        model_write(32'h00FF_0040, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        bus.addr = 32'h00FF_0040; bus.data_out = 16'h2222; bus.rw = 1'b0;
        bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.addr = 32'h00FF_0020; bus.data_out = 16'h9999;
        wait_dtack(1'b0, 8, e);
        check("addrchg_lat", 32'(e), 32'd3);
        release_bus("addrchg");
        do_read("r_2222", 32'h00FF_0040, rd);
        do_read("r_abcd_kept", 32'h00FF_0020, rd);

        // Asynchronous reset while dtack is low.
        @(negedge clk);
        bus.addr = 32'h00FF_0010; bus.rw = 1'b1; bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        wait_dtack(1'b0, 8, e);
        check("prerst_lat", 32'(e), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dtack", 32'(bus.dtack), 32'd1);
        check("async_rst_sel", 32'(bus.sel), 32'd0);
        check("async_rst_data", 32'(bus.data_in), 32'h0);
        @(negedge clk);
        bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a pending write: the write must be dropped.
        @(negedge clk);
        bus.addr = 32'h00FF_0010; bus.data_out = 16'h1111; bus.rw = 1'b0;
        bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("wrst_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1;
        @(negedge clk);

        // First cycle accepted on the first edge after reset release.
        rst_n = 1'b1;
        exp_q.push_back(model[int'(8)]);
        bus.addr = 32'h00FF_0010; bus.rw = 1'b1; bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        wait_dtack(1'b0, 8, e);
        check("postrst_lat", 32'(e), 32'd4);
        exp = exp_q.pop_front();
        check("postrst_data", 32'(bus.data_in), 32'(exp));
        check("postrst_beef_const", 32'(bus.data_in), 32'hBEEF);
        release_bus("postrst");

        // Interrupt acknowledge cycle.
`ifdef M68_RESP_INTACK_EN
        run_cycle("iack", 32'hFFFF_FFF8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16, acked, e, rd, s1, sa);
        check("iack_dtack", 32'(acked), 32'd1);
        check("iack_lat", 32'(e), 32'd4);
        check("iack_vector", 32'(rd), 32'h0040);
`else
        run_cycle("iack", 32'hFFFF_FFF8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 20, acked, e, rd, s1, sa);
        check("iack_no_dtack", 32'(acked), 32'd0);
        check("iack_no_sel", 32'(sa), 32'd0);
`endif
        do_read("r_final", 32'h00FF_0010, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m68_bus_responder.md
M68_BUS_RESPONDER -- requirements
Module: m68_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, 32'h00FF_0000, byte address of the 4 KB decode window; aligned to 4 KB.
REQ-002 Parameter WAIT_STATES, 2, clk cycles inserted between cycle capture and dtack assertion; legal range 0..15.
REQ-003 Parameter INT_VECTOR, 8'h40, vector number returned on interrupt-acknowledge cycles.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  32  byte address from the 68000 core (TG68).
REQ-007 data_out  input  16  write data from the core.
REQ-008 as  input  1  address strobe, active-low.
REQ-009 uds  input  1  upper data strobe, active-low; enables bits 15:8.
REQ-010 lds  input  1  lower data strobe, active-low; enables bits 7:0.
REQ-011 rw  input  1  1 = read, 0 = write.
REQ-012 intack  input  1  active-high interrupt-acknowledge qualifier from the core.
REQ-013 data_in  output  16  read data to the core.
REQ-014 dtack  output  1  data transfer acknowledge to the core, active-low.
REQ-015 sel  output  1  high while this block owns the current bus cycle (debug/arbiter visibility).

Function
REQ-016 Storage: 2048 x 16 word memory, indexed by addr[11:1]; addr[0] ignored.
REQ-017 Hit: cycle claimed when as == 0 and addr[31:12] == BASE_ADDR[31:12] (or intack == 1 with the macro enabled); non-hit cycles leave dtack high and sel low.
REQ-018 FSM states IDLE, WAIT, ACK, HOLD; reset state IDLE.
REQ-019 IDLE -> WAIT on first edge where a hit is sampled; addr, rw, uds, lds, data_out captured on that edge; sel goes high.
REQ-020 WAIT: counter loaded with WAIT_STATES, decrements each cycle; at zero -> ACK; WAIT_STATES == 0 passes through WAIT in one cycle (dtack low on 2nd edge after capture).
REQ-021 ACK: dtack driven low, data_in valid in the same cycle; writes committed exactly once on entry to ACK with per-lane enables from captured uds/lds.
REQ-022 Read returns full 16-bit word regardless of uds/lds.
REQ-023 Write with both uds and lds high: dtack asserted, memory unchanged.
REQ-024 ACK -> HOLD next edge; dtack held low in HOLD until as sampled high.
REQ-025 HOLD -> IDLE on edge where as == 1; dtack and sel return high on that edge; data_in returns 16'h0000.
REQ-026 Abort: as sampled high in WAIT -> IDLE, no write, dtack never asserted.
REQ-027 Back-to-back: new hit sampled in IDLE the edge after HOLD exit is accepted normally; no hit is captured while not in IDLE.
REQ-028 Captured address used for the whole cycle; addr changes after capture are ignored.

Reset
REQ-029 rst_n low: asynchronously state = IDLE, dtack = 1, sel = 0, data_in = 16'h0000, wait counter = 0.
REQ-030 Reset mid-cycle aborts any pending write; memory contents are not cleared by reset.
REQ-031 First cycle accepted on the first edge after rst_n deasserts with as == 0.

Configuration
REQ-032 Macro M68_RESP_INTACK_EN defined: intack == 1 with as == 0 is a hit regardless of addr; the cycle follows the normal FSM timing, returns data_in = {8'h00, INT_VECTOR}, and performs no memory access.
REQ-033 Macro M68_RESP_INTACK_EN undefined: intack ignored; cycles decoded by address only.

Verification
REQ-034 WAIT_STATES=2, write 16'hBEEF to 0x00FF_0010 (uds=lds=0) -> dtack low 4th edge after as low; later read of 0x00FF_0010 returns 16'hBEEF.
REQ-035 Word 0x00FF_0020 = 16'h1234; byte write uds=0, lds=1, data 16'hAB00 -> read returns 16'hAB34.
REQ-036 Read of 0x0000_0010 (out of window) -> dtack stays 1, sel stays 0 for 20 cycles.
REQ-037 as raised during WAIT of a write of 16'h5555 to 0x00FF_0030 -> no dtack; word unchanged.
REQ-038 rst_n pulsed low while dtack low -> dtack high immediately (before next edge), state IDLE, memory retains earlier 16'hBEEF.
REQ-039 With M68_RESP_INTACK_EN, intack=1, as=0, addr=0xFFFF_FFF8 -> data_in = 16'h0040 with dtack low; without macro -> no dtack.
